// File: rtl/bcd_pkg.sv
// Shared constants and types for the sequential BCD-to-binary converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: digit width, the largest legal BCD digit, the reverse
// double-dabble adjust threshold and constant, the controller state
// encoding, and a digit-validity helper.
package bcd_pkg;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_MAX_DIGIT  = 9;
    localparam int BCD_ADJ_THRESH = 8;
    localparam int BCD_ADJ_CONST  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // True when a 4-bit nibble is not a legal BCD digit (A..F).
    function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
        return d > BCD_DIGIT_W'(BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Single-digit correction step of reverse double-dabble.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
//
// Ports:
//   i_digit  4-bit digit value just after the right shift
//   o_digit  corrected digit: i_digit - 3 when i_digit >= 8, else i_digit
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    // After a right shift, a digit >= 8 has received the LSB of the next
    // decade up, worth 10/2 = 5 here instead of 8; subtracting 3 fixes it.
    // Wraps mod 16, which only matters for illegal input digits.
    assign o_digit = (i_digit >= BCD_DIGIT_W'(BCD_ADJ_THRESH))
                   ? i_digit - BCD_DIGIT_W'(BCD_ADJ_CONST)
                   : i_digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential multi-digit packed-BCD to unsigned binary converter (reverse double-dabble).
// Latency: start edge E0 -> done high in the cycle after edge E0+BIN_W+1; back in IDLE at E0+BIN_W+2.
// Backpressure: none; start is only sampled in IDLE, requests while busy or in DONE are dropped.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    conversion request, sampled only in IDLE
//   bcd_in   NDIGITS packed BCD digits, digit 0 in bits [3:0]; captured at the accepted start
//   busy     high while shifting (BIN_W cycles)
//   done     one-cycle pulse; bin_out (and err) valid from this cycle
//   bin_out  binary result, held until the next accepted start
//   err      invalid-digit flag
//
// Optional feature macro: BCD_DIGIT_CHECK_EN
//   defined   : any digit > 9 at the accepted start sets err with the done pulse and
//               forces bin_out to 0; conversion length is unchanged.
//   undefined : no check, err is tied 0 and illegal digits run through the algorithm as-is.
//
// Cycle map for one conversion (BIN_W = 7):
//   E0       IDLE  -> SHIFT, operands captured, busy rises
//   E1..E7   one shift+adjust per edge; at E7 -> DONE, busy falls
//   E8       DONE  -> IDLE, bin_out/err loaded, done rises for one cycle
//   E9       first edge that can accept a new start
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 2,
    parameter int BIN_W   = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [BCD_DIGIT_W*NDIGITS-1:0] bcd_in,
    output logic                         busy,
    output logic                         done,
    output logic [BIN_W-1:0]             bin_out,
    output logic                         err
);

    localparam int BCD_W = BCD_DIGIT_W * NDIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_t             r_state;
    logic [BCD_W-1:0]   r_bcd;
    logic [BIN_W-1:0]   r_bin;
    logic [CNT_W-1:0]   r_cnt;

    logic [BCD_W-1:0]   w_shift_bcd;
    logic [BIN_W-1:0]   w_shift_bin;
    logic [BCD_W-1:0]   w_adj_bcd;

    // Shift the concatenation {bcd, bin} right by one: the BCD LSB
    // becomes the new binary MSB.
    assign w_shift_bcd = r_bcd >> 1;
    assign w_shift_bin = {r_bcd[0], r_bin[BIN_W-1:1]};

    // Correct every post-shift digit in parallel.
    for (genvar g_dig = 0; g_dig < NDIGITS; g_dig++) begin : g_adjust
        bcd_digit_adjust u_adj (
            .i_digit (w_shift_bcd[g_dig*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_adj_bcd[g_dig*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic r_dig_err;
    logic w_in_err;

    always_comb begin
        w_in_err = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (digit_invalid(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                w_in_err = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
`ifdef BCD_DIGIT_CHECK_EN
            r_dig_err <= 1'b0;
            err       <= 1'b0;
`endif
        end else begin
            // done is a single-cycle pulse unless DONE re-asserts it below.
            done <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bcd   <= bcd_in;
                        r_bin   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= SHIFT;
`ifdef BCD_DIGIT_CHECK_EN
                        r_dig_err <= w_in_err;
                        err       <= 1'b0;
`endif
                    end
                end

                SHIFT: begin
                    r_bcd <= w_adj_bcd;
                    r_bin <= w_shift_bin;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // This edge performs shift number r_cnt+1; the last one
                    // is shift BIN_W.
                    if (r_cnt == LAST_CNT) begin
                        busy    <= 1'b0;
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    // Result register loads here so bin_out and done rise together.
                    done    <= 1'b1;
                    r_state <= IDLE;
`ifdef BCD_DIGIT_CHECK_EN
                    err     <= r_dig_err;
                    bin_out <= r_dig_err ? '0 : r_bin;
`else
                    bin_out <= r_bin;
`endif
                end

                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifndef BCD_DIGIT_CHECK_EN
    assign err = 1'b0;
`endif

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential multi-digit BCD-to-binary converter. It is the inverse path of the team's 4-bit BCD adder.
- It takes packed BCD digits, as produced by the BCD sum chain, and returns the unsigned binary value.
- Algorithm is reverse double-dabble: one bit per clock, start/busy/done handshake.
- Sits between the BCD arithmetic datapath and any binary consumer (display driver, comparator, bench checker).

Parameters:
- NDIGITS, 2, number of packed BCD digits on bcd_in.
- BIN_W, 7, binary output width. Must satisfy 2^BIN_W > 10^NDIGITS - 1. Equals conversion length in cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion. Sampled only in IDLE.
- bcd_in  input  4*NDIGITS  packed BCD. Digit 0 is in bits [3:0].
- busy  output  1  high while converting.
- done  output  1  one-cycle pulse when bin_out is valid.
- bin_out  output  BIN_W  binary result. Held until the next accepted start.
- err  output  1  invalid-digit flag (see Optional Feature). Constant 0 if the feature is out.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, err=0, bin_out=0; internal BCD shift reg=0, bit counter=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: latch bcd_in into the BCD shift reg, clear the binary shift reg, counter=0, go to SHIFT, busy=1 from the next cycle.
  - start=0: remain in IDLE.
- SHIFT: each edge, in this order:
  - (a) shift {bcd_reg, bin_reg} right by 1; the LSB of bcd_reg enters the MSB of bin_reg;
  - (b) in every post-shift digit, value >= 8 -> subtract 3 (mod 16);
  - (c) counter+1.
  - After BIN_W shifts, go to DONE.
- DONE:
  - Load bin_out from bin_reg.
  - done=1 and busy=0 for exactly this cycle.
  - Next edge returns to IDLE.
- Latency: start sampled at edge E0 -> done high during the cycle after edge E0+BIN_W+1. Total BIN_W+2 cycles from the start edge to return to IDLE.
- start while busy or in DONE: ignored. No queueing, no restart.
- start held high continuously: a new conversion is accepted on the first edge in IDLE after DONE. Back-to-back throughput is BIN_W+2 cycles.
- bcd_in only matters at the accepted start edge. Later changes do not affect the current conversion.
- Reset mid-conversion: immediate return to reset values. done is not emitted and bin_out is cleared.
- Maximum input, all digits 9: result fits BIN_W with no overflow, given the parameter constraint.
- BIN_W is greater than or equal to the width needed for the result. Any extra upper bits of bin_out are 0.

Optional Feature:
- Macro BCD_DIGIT_CHECK_EN.
- Defined:
  - At the accepted start, any digit > 9 sets an error flag.
  - The conversion still runs full length, so latency is unchanged.
  - In DONE: err=1 for the done cycle, and bin_out is forced to 0.
  - err is cleared at the next accepted start.
- Undefined:
  - No check; err is tied 0.
  - Invalid digits are processed by the algorithm unchanged; the result is defined by the algorithm only, not the mathematical value.

Decomposition:
- Package bcd_pkg holds:
  - BCD_DIGIT_W=4.
  - BCD_MAX_DIGIT=9.
  - Adjust threshold 8 and adjust constant 3.
  - State enum {IDLE, SHIFT, DONE}.
- One natural sub-module: bcd_digit_adjust. Combinational 4-bit in/out: subtract 3 if >= 8. Instantiated NDIGITS times via generate.

Test Plan:
1. Reset asserted mid-SHIFT, e.g. after 3 cycles of converting bcd_in=8'h42 -> busy/done/bin_out/err go to 0 immediately. After release, a fresh start with 8'h42 yields 42 normally.
2. Defaults, bcd_in=8'h42, start pulse -> busy for 7 cycles, then done=1 for one cycle, bin_out=7'd42, err=0. Total 9 cycles back to IDLE.
3. bcd_in=8'h99 -> bin_out=7'd99. Then bcd_in=8'h00 -> bin_out=0. Then 8'h10 -> bin_out=10.
4. start held high across two conversions (8'h37 then 8'h05) -> two done pulses 9 cycles apart with 37 and 5. A start pulse injected mid-SHIFT is ignored.
5. With BCD_DIGIT_CHECK_EN, bcd_in=8'h9A -> done after the same latency with err=1, bin_out=0. Next start with 8'h09 -> err=0, bin_out=9.
6. NDIGITS=3, BIN_W=10, bcd_in=12'h999 -> bin_out=10'd999 after 10 busy cycles. Exhaustive sweep 000..999 matches the integer model.
